// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with registered data, ack/err pulses and occupancy flags.
// Despite the name, reads and writes share wr_clk; clear_n resets asynchronously.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  wr_clk,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  full_q, afull_q, empty_q, aempty_q;
    logic                  wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
    logic                  wr_ok, rd_ok;

    // Flags are registered, so acceptance uses the flag state from the previous edge.
    always_comb begin
        wr_ok   = wr_en && !full_q;
        rd_ok   = rd_en && !empty_q;
        count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge wr_clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                dout_q   <= mem_q[rd_ptr_q];
            end
            count_q  <= count_d;
            full_q   <= count_d == FULL_C;
            afull_q  <= count_d >= FULL_C - 1'b1;
            empty_q  <= count_d == '0;
            aempty_q <= count_d <= (AW+1)'(1);
            wr_ack_q <= wr_ok;
            wr_err_q <= wr_en && full_q;
            rd_ack_q <= rd_ok;
            rd_err_q <= rd_en && empty_q;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;
    assign dout         = dout_q;
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: scoreboard bench; a queue model predicts data, flags and ack/err pulses.
module tb_async_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          wr_clk = 1'b0;
    logic          clear_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0, rd_en = 1'b0;
    logic          full, almost_full, wr_ack, wr_err, empty, almost_empty, rd_ack, rd_err;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_dout = '0;
    int cnt = 0;

    async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .wr_clk(wr_clk), .clear_n(clear_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .full(full), .almost_full(almost_full), .wr_ack(wr_ack), .wr_err(wr_err),
        .empty(empty), .almost_empty(almost_empty), .rd_ack(rd_ack), .rd_err(rd_err),
        .dout(dout)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".full"}, full, cnt == DEPTH);
        chk({tag, ".afull"}, almost_full, cnt >= DEPTH - 1);
        chk({tag, ".empty"}, empty, cnt == 0);
        chk({tag, ".aempty"}, almost_empty, cnt <= 1);
        chk({tag, ".dout"}, dout, exp_dout);
    endtask

    task automatic cycle(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        logic w_ok, r_ok;
        @(negedge wr_clk);
        wr_en = w;
        rd_en = r;
        din = d;
        w_ok = w && cnt < DEPTH;
        r_ok = r && cnt > 0;
        if (r_ok) begin
            exp_dout = sb_q.pop_front();
            cnt--;
        end
        if (w_ok) begin
            sb_q.push_back(d);
            cnt++;
        end
        @(posedge wr_clk);
        #1;
        chk({tag, ".wr_ack"}, wr_ack, w_ok);
        chk({tag, ".wr_err"}, wr_err, w && !w_ok);
        chk({tag, ".rd_ack"}, rd_ack, r_ok);
        chk({tag, ".rd_err"}, rd_err, r && !r_ok);
        chk_flags(tag);
    endtask

    task automatic async_reset(input string tag);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear_n = 1'b0;
        sb_q.delete();
        cnt = 0;
        exp_dout = '0;
        #1;
        chk({tag, ".wr_ack"}, wr_ack, 0);
        chk({tag, ".wr_err"}, wr_err, 0);
        chk({tag, ".rd_ack"}, rd_ack, 0);
        chk({tag, ".rd_err"}, rd_err, 0);
        chk_flags(tag);
        @(negedge wr_clk);
        clear_n = 1'b1;
    endtask

    initial begin
        #12;
        async_reset("rst");
        cycle("idle", 0, 0, 8'h00);
        for (int i = 1; i <= 17; i++) cycle("fill", 1, 0, DW'(i));
        for (int i = 1; i <= 17; i++) cycle("drain", 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) cycle("pre", 1, 0, DW'(8'h40 + i));
        for (int i = 0; i < 20; i++) cycle("both", 1, 1, DW'($urandom_range(0, 255)));
        while (cnt < DEPTH) cycle("top", 1, 0, DW'($urandom_range(0, 255)));
        cycle("both_full", 1, 1, 8'hAA);
        while (cnt > 0) cycle("bottom", 0, 1, 8'h00);
        cycle("both_empty", 1, 1, 8'h55);
        cycle("pop", 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 0, DW'(8'hC0 + i));
        async_reset("mid_rst");
        cycle("post_rst", 0, 1, 8'h00);
        cycle("post_rst_wr", 1, 0, 8'h77);
        cycle("post_rst_rd", 0, 1, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
